// File: rtl/census_hamming_cost_pkg.sv
// Shared helpers for the census matching-cost stage: sizing functions used to derive
// pipeline depth, sum width and the popcount-tree node layout from module parameters.
package census_hamming_cost_pkg;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r++;
        return r;
    endfunction

    function automatic int unsigned sum_wid(input int unsigned ct_wid);
        return clog2(ct_wid + 1);
    endfunction

    // XOR stage + one register per tree level + saturation stage
    function automatic int unsigned lat(input int unsigned ct_wid);
        return clog2(ct_wid) + 2;
    endfunction

    function automatic int unsigned cost_max(input int unsigned cost_wid);
        return (32'd1 << cost_wid) - 32'd1;
    endfunction

    // Number of nodes at tree level l (level 0 = the input bits)
    function automatic int unsigned pop_cnt(input int unsigned w, input int unsigned l);
        return (w + (32'd1 << l) - 32'd1) >> l;
    endfunction

    // Offset of level l (l >= 1) in the flattened node storage
    function automatic int unsigned pop_off(input int unsigned w, input int unsigned l);
        int unsigned s;
        s = 0;
        for (int unsigned k = 1; k < l; k++) s += pop_cnt(w, k);
        return s;
    endfunction

endpackage

// File: rtl/census_hamming_cost_popcount_tree.sv
// Pipelined binary popcount: one register level per pairwise-add level, odd leftover
// node at each level is passed through by adding zero.
module census_hamming_cost_popcount_tree
    import census_hamming_cost_pkg::*;
#(
    parameter int unsigned IN_WID  = 62,
    parameter int unsigned OUT_WID = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               en_i,
    input  logic [IN_WID-1:0]  din_i,
    output logic [OUT_WID-1:0] dout_o
);
    localparam int unsigned NUM_LVL  = clog2(IN_WID);
    localparam int unsigned NUM_NODE = pop_off(IN_WID, NUM_LVL + 1);

    // Every node is sized to the final width; a partial sum never exceeds IN_WID.
    logic [NUM_NODE*OUT_WID-1:0] node_d, node_q;

    for (genvar l = 1; l <= NUM_LVL; l++) begin : g_lvl
        for (genvar i = 0; i < pop_cnt(IN_WID, l); i++) begin : g_node
            logic [OUT_WID-1:0] a, b;
            if (l == 1) begin : g_leaf
                assign a = OUT_WID'(din_i[2*i]);
                if (2 * i + 1 < IN_WID) begin : g_pair
                    assign b = OUT_WID'(din_i[2*i+1]);
                end else begin : g_odd
                    assign b = '0;
                end
            end else begin : g_inner
                assign a = node_q[(pop_off(IN_WID, l - 1) + 2*i)*OUT_WID +: OUT_WID];
                if (2 * i + 1 < pop_cnt(IN_WID, l - 1)) begin : g_pair
                    assign b = node_q[(pop_off(IN_WID, l - 1) + 2*i + 1)*OUT_WID +: OUT_WID];
                end else begin : g_odd
                    assign b = '0;
                end
            end
            assign node_d[(pop_off(IN_WID, l) + i)*OUT_WID +: OUT_WID] = a + b;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            node_q <= '0;
        end else if (en_i) begin
            node_q <= node_d;
        end
    end

    assign dout_o = node_q[(NUM_NODE-1)*OUT_WID +: OUT_WID];

endmodule

// File: rtl/census_hamming_cost.sv
// Census matching cost: Hamming distance between the left census word and the last
// MAX_DISP right census words, with left-border masking, saturation and SOF/EOL sideband.
module census_hamming_cost
    import census_hamming_cost_pkg::*;
#(
    parameter int unsigned MAX_DISP   = 64,
    parameter int unsigned CT_WID     = 62,
    parameter int unsigned COST_WID   = 6,
    parameter bit          BORDER_MAX = 1'b1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         en_i,
    input  logic                         valid_i,
    input  logic                         sof_i,
    input  logic                         eol_i,
    input  logic [CT_WID-1:0]            left_ct_i,
    input  logic [CT_WID-1:0]            right_ct_i,
    output logic                         valid_o,
    output logic                         sof_o,
    output logic                         eol_o,
    output logic [MAX_DISP*COST_WID-1:0] cost_o
);
    localparam int unsigned SUM_WID  = sum_wid(CT_WID);
    localparam int unsigned NUM_LVL  = clog2(CT_WID);
    localparam int unsigned LAT      = lat(CT_WID);
    localparam int unsigned CNT_WID  = clog2(MAX_DISP + 1);
    localparam int unsigned COST_MAX = cost_max(COST_WID);

    logic [CT_WID-1:0]            rline_q [MAX_DISP-1];
    logic [CNT_WID-1:0]           x_q, x_d, x_cur;
    logic [CT_WID-1:0]            xor_q [MAX_DISP];
    logic [MAX_DISP-1:0]          bord_d;
    logic [MAX_DISP-1:0]          bord_q [NUM_LVL+1];
    logic [LAT-1:0]               vld_q, sof_q, eol_q;
    logic [SUM_WID-1:0]           sum [MAX_DISP];
    logic [MAX_DISP*COST_WID-1:0] cost_d, cost_q;

    // A new line starts on sof_i even without a preceding eol_i.
    assign x_cur = sof_i ? '0 : x_q;

    always_comb begin
        x_d = x_cur;
        if (eol_i) begin
            x_d = '0;
        end else if (x_cur != CNT_WID'(MAX_DISP)) begin
            x_d = x_cur + CNT_WID'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < MAX_DISP - 1; i++) rline_q[i] <= '0;
            x_q <= '0;
        end else if (en_i && valid_i) begin
            rline_q[0] <= right_ct_i;
            for (int unsigned i = 1; i < MAX_DISP - 1; i++) rline_q[i] <= rline_q[i-1];
            x_q <= x_d;
        end
    end

    always_comb begin
        bord_d = '0;
        for (int unsigned d = 0; d < MAX_DISP; d++) bord_d[d] = (d > 32'(x_cur));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned d = 0; d < MAX_DISP; d++) xor_q[d] <= '0;
            for (int unsigned k = 0; k <= NUM_LVL; k++) bord_q[k] <= '0;
            vld_q  <= '0;
            sof_q  <= '0;
            eol_q  <= '0;
            cost_q <= '0;
        end else if (en_i) begin
            xor_q[0] <= left_ct_i ^ right_ct_i;
            for (int unsigned d = 1; d < MAX_DISP; d++) xor_q[d] <= left_ct_i ^ rline_q[d-1];
            bord_q[0] <= bord_d;
            for (int unsigned k = 1; k <= NUM_LVL; k++) bord_q[k] <= bord_q[k-1];
            vld_q  <= {vld_q[LAT-2:0], valid_i};
            sof_q  <= {sof_q[LAT-2:0], valid_i & sof_i};
            eol_q  <= {eol_q[LAT-2:0], valid_i & eol_i};
            cost_q <= cost_d;
        end
    end

    for (genvar d = 0; d < MAX_DISP; d++) begin : g_disp
        census_hamming_cost_popcount_tree #(
            .IN_WID (CT_WID),
            .OUT_WID(SUM_WID)
        ) u_popcount (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .en_i  (en_i),
            .din_i (xor_q[d]),
            .dout_o(sum[d])
        );
    end

    always_comb begin
        cost_d = '0;
        for (int unsigned d = 0; d < MAX_DISP; d++) begin
            if (BORDER_MAX && bord_q[NUM_LVL][d]) begin
                cost_d[d*COST_WID +: COST_WID] = '1;
            end else if (32'(sum[d]) > COST_MAX) begin
                cost_d[d*COST_WID +: COST_WID] = COST_WID'(COST_MAX);
            end else begin
                cost_d[d*COST_WID +: COST_WID] = COST_WID'(sum[d]);
            end
        end
    end

    assign valid_o = vld_q[LAT-1];
    assign sof_o   = sof_q[LAT-1];
    assign eol_o   = eol_q[LAT-1];
    assign cost_o  = cost_q;

endmodule

// File: tb/tb_census_hamming_cost.sv
// Bench for census_hamming_cost: directed line scenarios plus randomized stall/gap traffic,
// checked every enabled cycle against a queue-based model of the matching-cost rules.
module tb_census_hamming_cost;
    localparam int MD   = 16;
    localparam int CT   = 79;
    localparam int CW   = 6;
    localparam int CMAX = 63;
    localparam int LAT  = 9;  // 7 adder levels for 79 bits, plus XOR and output registers

    typedef logic [CT-1:0]    ct_t;
    typedef logic [MD*CW-1:0] cv_t;

    typedef struct {
        logic sof;
        logic eol;
        cv_t  cost;
        int   due;
        int   lit0;
        int   lit1;
        int   litn;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1, en = 1'b0, valid = 1'b0, sof = 1'b0, eol = 1'b0;
    ct_t  left_ct = '0, right_ct = '0;
    logic valid_o, sof_o, eol_o;
    cv_t  cost;

    int   lit0_in = -1, lit1_in = -1, litn_in = -1;
    exp_t expq[$];
    ct_t  hist[$];
    int   line_pos = 0;
    int   ecnt = 0;
    int   checks = 0, errors = 0;

    census_hamming_cost #(
        .MAX_DISP  (MD),
        .CT_WID    (CT),
        .COST_WID  (CW),
        .BORDER_MAX(1'b1)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .valid_i   (valid),
        .sof_i     (sof),
        .eol_i     (eol),
        .left_ct_i (left_ct),
        .right_ct_i(right_ct),
        .valid_o   (valid_o),
        .sof_o     (sof_o),
        .eol_o     (eol_o),
        .cost_o    (cost)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [127:0] act,
                                input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endfunction

    function automatic int exp_cost(input ct_t l, input ct_t r, input int d, input int x);
        int n;
        if (d > x) return CMAX;
        n = $countones(l ^ r);
        return (n > CMAX) ? CMAX : n;
    endfunction

    // Model of one accepted pixel; hist holds earlier right words, most recent first.
    function automatic void model_accept();
        exp_t e;
        ct_t  r;
        int   x;
        x = sof ? 0 : line_pos;
        e.cost = '0;
        for (int d = 0; d < MD; d++) begin
            if (d == 0) r = right_ct;
            else if (d - 1 < hist.size()) r = hist[d-1];
            else r = '0;
            e.cost[d*CW +: CW] = CW'(exp_cost(left_ct, r, d, x));
        end
        e.sof  = sof;
        e.eol  = eol;
        e.due  = ecnt + LAT - 1;
        e.lit0 = lit0_in;
        e.lit1 = lit1_in;
        e.litn = litn_in;
        expq.push_back(e);
        hist.push_front(right_ct);
        if (hist.size() > MD) void'(hist.pop_back());
        line_pos = eol ? 0 : ((x + 1 > MD) ? MD : x + 1);
    endfunction

    initial begin : compare
        exp_t e;
        logic en_s, pv;
        cv_t  pc;
        pv = 1'b0;
        pc = '0;
        forever begin
            @(posedge clk);
            if (rst) begin
                #1;
                pv = valid_o;
                pc = cost;
                continue;
            end
            en_s = en;
            if (en) begin
                ecnt++;
                if (valid) model_accept();
            end
            #1;
            if (!en_s) begin
                chk("hold_valid", valid_o, pv);
                chk("hold_cost", cost, pc);
            end else if (valid_o) begin
                if (expq.size() == 0) begin
                    chk("spurious_valid", valid_o, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("latency", ecnt, e.due);
                    chk("sof_out", sof_o, e.sof);
                    chk("eol_out", eol_o, e.eol);
                    chk("cost", cost, e.cost);
                    if (e.lit0 >= 0) chk("lit_cost0", cost[0 +: CW], e.lit0);
                    if (e.lit1 >= 0) chk("lit_cost1", cost[CW +: CW], e.lit1);
                    if (e.litn >= 0) chk("lit_costn", cost[(MD-1)*CW +: CW], e.litn);
                end
            end else if (expq.size() != 0 && expq[0].due <= ecnt) begin
                chk("missing_valid", valid_o, 1'b1);
                void'(expq.pop_front());
            end
            pv = valid_o;
            pc = cost;
        end
    end

    task automatic px(input ct_t l, input ct_t r, input logic s, input logic e,
                      input int q0, input int q1, input int qn);
        @(negedge clk);
        en = 1'b1; valid = 1'b1; sof = s; eol = e; left_ct = l; right_ct = r;
        lit0_in = q0; lit1_in = q1; litn_in = qn;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            en = 1'b1; valid = 1'b0; sof = 1'b0; eol = 1'b0;
            lit0_in = -1; lit1_in = -1; litn_in = -1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_sof", sof_o, 1'b0);
        chk("rst_eol", eol_o, 1'b0);
        chk("rst_cost", cost, '0);
        expq.delete();
        hist.delete();
        line_pos = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic ct_t rand_ct();
        return ct_t'({$urandom, $urandom, $urandom});
    endfunction

    initial begin : main
        ct_t c, z, t, m, lc;
        c = ct_t'({40{2'b10}});
        z = '0;
        t = ct_t'(7);
        m = ct_t'({62{1'b1}});

        chk("pin_equal", exp_cost(c, c, 0, 0), 0);
        chk("pin_complement", exp_cost(c, ~c, 0, 0), 63);
        chk("pin_three", exp_cost(z, t, 0, 0), 3);
        chk("pin_border", exp_cost(c, c, 3, 2), 63);

        repeat (3) @(negedge clk);
        #1;
        chk("init_valid", valid_o, 1'b0);
        chk("init_cost", cost, '0);
        rst = 1'b0;

        // Identical streams: zero cost inside the border, all-ones outside.
        for (int i = 0; i < 30; i++)
            px(c, c, i == 0, i == 29, 0, (i >= 1) ? 0 : 63, (i >= MD - 1) ? 0 : 63);
        // 62 differing bits: below saturation.
        lc = rand_ct();
        for (int i = 0; i < 20; i++)
            px(lc, lc ^ m, i == 0, i == 19, 62, (i >= 1) ? 62 : 63, (i >= MD - 1) ? 62 : 63);
        // Full complement of 79 bits must clamp to 63.
        lc = rand_ct();
        for (int i = 0; i < 20; i++)
            px(lc, ~lc, i == 0, i == 19, 63, 63, 63);
        // Line of 41 pixels, then restart without sof; then a one-pixel line.
        for (int i = 0; i < 41; i++) px(rand_ct(), rand_ct(), i == 0, i == 40, -1, -1, -1);
        px(c, c, 1'b0, 1'b0, 0, 63, 63);
        px(c, c, 1'b1, 1'b1, 0, 63, 63);
        idle(LAT + 2);

        for (int cyc = 0; cyc < 2500; cyc++) begin
            if (cyc == 1200) do_reset();
            @(negedge clk);
            en    = ($urandom_range(0, 3) != 0);
            valid = ($urandom_range(0, 9) < 7);
            sof   = ($urandom_range(0, 39) == 0);
            eol   = ($urandom_range(0, 24) == 0);
            lit0_in = -1; lit1_in = -1; litn_in = -1;
            left_ct = rand_ct();
            case ($urandom_range(0, 3))
                0: right_ct = left_ct ^ (ct_t'(1) << $urandom_range(0, CT - 1))
                                      ^ (ct_t'(1) << $urandom_range(0, CT - 1));
                1: right_ct = ~left_ct;
                default: right_ct = rand_ct();
            endcase
        end

        idle(LAT + 4);
        chk("drain_empty", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
